// File: rtl/cam_capture_ctrl.sv
// -----------------------------------------------------------------------------
// cam_capture_ctrl
//
// Camera frame-capture sequencer. The asynchronous camera interface
// (vsync/href/pclk/data) is oversampled in the system clock domain. A host
// arms a single-shot or continuous capture over a small CSR bus. Pixel bytes
// that fall inside a programmable line window are streamed to a downstream
// frame FIFO. An interrupt is raised on frame done or on FIFO overflow.
//
// Ports
//   clk            system clock, the only clock
//   reset_n        synchronous active-low reset
//   chip_select    CSR access enable
//   csr_address    CSR register index (5 bits)
//   csr_read       read strobe; registered data appears on the next cycle
//   csr_readdata   registered read data; holds until the next read
//   csr_write      write strobe; takes effect on the next cycle
//   csr_writedata  write data (8 bits)
//   irq            |(IRQ_FLAG & IRQ_EN)
//   cam_vsync      async, high between frames
//   cam_href       async, high during an active line
//   cam_pclk       async pixel clock; data is valid at its rising edge
//   cam_data       async pixel byte
//   pix_valid      one-cycle strobe qualifying pix_data
//   pix_data       captured pixel byte
//   fifo_full      downstream FIFO cannot accept a pixel this cycle
//   frame_start    one-cycle pulse when a captured frame begins
//
// CSR map: 0 CTRL {ABORT,CONT,ARM}, 1 STATUS {busy,state}, 2 IRQ_EN,
//          3 IRQ_FLAG (W1C), 4 LINE_START, 5 LINE_CNT, 6 FRAME_CNT (RO).
// -----------------------------------------------------------------------------
module cam_capture_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int LINE_W      = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       chip_select,
    input  logic [4:0] csr_address,
    input  logic       csr_read,
    output logic [7:0] csr_readdata,
    input  logic       csr_write,
    input  logic [7:0] csr_writedata,
    output logic       irq,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic       cam_pclk,
    input  logic [7:0] cam_data,
    output logic       pix_valid,
    output logic [7:0] pix_data,
    input  logic       fifo_full,
    output logic       frame_start
);

    // A single-flop synchroniser is never safe, so the depth is clamped to 2.
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_VS  = 3'd1,
        ST_WAIT_FRM = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [SS-1:0]      vs_sync_q;
    logic [SS-1:0]      hr_sync_q;
    logic [SS-1:0]      pc_sync_q;
    logic [SS-1:0][7:0] data_pipe_q;
    logic               vs_dly_q;
    logic               hr_dly_q;
    logic               pc_dly_q;

    logic               vs_rise_s;
    logic               vs_fall_s;
    logic               hr_fall_s;
    logic               pc_rise_s;
    logic               href_s;
    logic [7:0]         cam_byte_s;

    state_e             state_q, state_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic               pix_valid_q, pix_valid_d;
    logic [7:0]         pix_data_q, pix_data_d;
    logic               frame_start_q, frame_start_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;

    logic               cont_q;
    logic [1:0]         irq_en_q;
    logic [1:0]         irq_flag_q, irq_flag_d;
    logic [LINE_W-1:0]  line_start_q;
    logic [LINE_W-1:0]  line_cnt_q;
    logic [7:0]         csr_readdata_q, rdata_s;

    logic               wr_en_s;
    logic               rd_en_s;
    logic               wr_ctrl_s;
    logic               arm_s;
    logic               abort_s;
    logic [1:0]         w1c_s;
    logic               set_done_s;
    logic               set_ovf_s;

    logic [LINE_W+7:0]  wdata_wide_s;
    logic [LINE_W-1:0]  wdata_line_s;
    logic [LINE_W+7:0]  ls_wide_s;
    logic [LINE_W+7:0]  lc_wide_s;

    logic [LINE_W:0]    line_ext_s;
    logic [LINE_W:0]    start_ext_s;
    logic [LINE_W:0]    end_ext_s;
    logic               in_window_s;
    logic               win_end_s;
    logic               line_max_s;

    // ------------------------------------------------------------------
    // Camera input synchronisers and edge history
    // ------------------------------------------------------------------
    // Shift async camera signals through SS flops; data follows pclk so the
    // byte at the detected pclk rise is the one present when pclk rose.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vs_sync_q   <= {SS{1'b0}};
            hr_sync_q   <= {SS{1'b0}};
            pc_sync_q   <= {SS{1'b0}};
            data_pipe_q <= {(SS*8){1'b0}};
            vs_dly_q    <= 1'b0;
            hr_dly_q    <= 1'b0;
            pc_dly_q    <= 1'b0;
        end else begin
            vs_sync_q   <= {vs_sync_q[SS-2:0], cam_vsync};
            hr_sync_q   <= {hr_sync_q[SS-2:0], cam_href};
            pc_sync_q   <= {pc_sync_q[SS-2:0], cam_pclk};
            data_pipe_q <= {data_pipe_q[SS-2:0], cam_data};
            vs_dly_q    <= vs_sync_q[SS-1];
            hr_dly_q    <= hr_sync_q[SS-1];
            pc_dly_q    <= pc_sync_q[SS-1];
        end
    end

    assign vs_rise_s  =  vs_sync_q[SS-1] & ~vs_dly_q;
    assign vs_fall_s  = ~vs_sync_q[SS-1] &  vs_dly_q;
    assign hr_fall_s  = ~hr_sync_q[SS-1] &  hr_dly_q;
    assign pc_rise_s  =  pc_sync_q[SS-1] & ~pc_dly_q;
    assign href_s     =  hr_sync_q[SS-1];
    assign cam_byte_s =  data_pipe_q[SS-1];

    // ------------------------------------------------------------------
    // CSR decode
    // ------------------------------------------------------------------
    assign wr_en_s   = chip_select & csr_write;
    assign rd_en_s   = chip_select & csr_read;
    assign wr_ctrl_s = wr_en_s & (csr_address == 5'd0);
    // ABORT takes priority over an ARM carried in the same write.
    assign abort_s   = wr_ctrl_s & csr_writedata[2];
    assign arm_s     = wr_ctrl_s & csr_writedata[0] & ~csr_writedata[2];
    assign w1c_s     = (wr_en_s && (csr_address == 5'd3)) ? csr_writedata[1:0] : 2'b00;

    // Resize between the 8-bit bus and LINE_W-bit window registers.
    assign wdata_wide_s = {{LINE_W{1'b0}}, csr_writedata};
    assign wdata_line_s = wdata_wide_s[LINE_W-1:0];
    assign ls_wide_s    = {8'h00, line_start_q};
    assign lc_wide_s    = {8'h00, line_cnt_q};

    // ------------------------------------------------------------------
    // Line window; one extra bit so LINE_START+LINE_CNT never wraps
    // ------------------------------------------------------------------
    assign line_ext_s  = {1'b0, line_q};
    assign start_ext_s = {1'b0, line_start_q};
    assign end_ext_s   = start_ext_s + {1'b0, line_cnt_q};
    assign in_window_s = (line_ext_s >= start_ext_s) &&
                         ((line_cnt_q == {LINE_W{1'b0}}) || (line_ext_s < end_ext_s));
    assign win_end_s   = (line_cnt_q != {LINE_W{1'b0}}) && (line_ext_s == end_ext_s);
    assign line_max_s  = (line_q == {LINE_W{1'b1}});

    // ------------------------------------------------------------------
    // Capture FSM: next state, pixel strobe and event flags
    // ------------------------------------------------------------------
    // Next-state and output decode; ABORT overrides everything at the end.
    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        frame_start_d = 1'b0;
        set_done_s    = 1'b0;
        set_ovf_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm_s) begin
                    state_d = ST_WAIT_VS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_VS: begin
                if (vs_rise_s) begin
                    state_d = ST_WAIT_FRM;
                end else begin
                    state_d = ST_WAIT_VS;
                end
            end
            ST_WAIT_FRM: begin
                if (vs_fall_s) begin
                    state_d       = ST_CAPTURE;
                    line_d        = {LINE_W{1'b0}};
                    frame_start_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_FRM;
                end
            end
            ST_CAPTURE: begin
                // Saturate rather than wrap so an unbounded window stays open.
                if (hr_fall_s && !line_max_s) begin
                    line_d = line_q + {{(LINE_W-1){1'b0}}, 1'b1};
                end else begin
                    line_d = line_q;
                end
                if (pc_rise_s && href_s && in_window_s) begin
                    if (fifo_full) begin
                        set_ovf_s = 1'b1;
                    end else begin
                        pix_valid_d = 1'b1;
                        pix_data_d  = cam_byte_s;
                    end
                end else begin
                    pix_valid_d = 1'b0;
                end
                if (win_end_s || vs_rise_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                set_done_s = 1'b1;
                // In continuous mode the vsync-high that ended this frame is
                // the gap, so go straight to waiting for its falling edge.
                if (cont_q) begin
                    state_d = ST_WAIT_FRM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_s) begin
            state_d       = ST_IDLE;
            pix_valid_d   = 1'b0;
            frame_start_d = 1'b0;
            set_done_s    = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // Flag and frame counter next-state; a set beats a same-cycle clear.
    always_comb begin
        irq_flag_d = (irq_flag_q & ~w1c_s) | {set_ovf_s, set_done_s};
        if (set_done_s) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            line_q        <= {LINE_W{1'b0}};
            pix_valid_q   <= 1'b0;
            pix_data_q    <= 8'h00;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'h00;
            irq_flag_q    <= 2'b00;
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            irq_flag_q    <= irq_flag_d;
        end
    end

    // ------------------------------------------------------------------
    // Writable CSRs
    // ------------------------------------------------------------------
    // Host-written configuration; ABORT also drops continuous mode.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cont_q       <= 1'b0;
            irq_en_q     <= 2'b00;
            line_start_q <= {LINE_W{1'b0}};
            line_cnt_q   <= {LINE_W{1'b0}};
        end else begin
            if (abort_s) begin
                cont_q <= 1'b0;
            end else if (wr_ctrl_s) begin
                cont_q <= csr_writedata[1];
            end
            if (wr_en_s && (csr_address == 5'd2)) begin
                irq_en_q <= csr_writedata[1:0];
            end
            if (wr_en_s && (csr_address == 5'd4)) begin
                line_start_q <= wdata_line_s;
            end
            if (wr_en_s && (csr_address == 5'd5)) begin
                line_cnt_q <= wdata_line_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // CSR read path
    // ------------------------------------------------------------------
    // Read mux; ARM/ABORT are self-clearing and always read back as 0.
    always_comb begin
        case (csr_address)
            5'd0:    rdata_s = {6'b000000, cont_q, 1'b0};
            5'd1:    rdata_s = {4'b0000, (state_q != ST_IDLE), state_q};
            5'd2:    rdata_s = {6'b000000, irq_en_q};
            5'd3:    rdata_s = {6'b000000, irq_flag_q};
            5'd4:    rdata_s = ls_wide_s[7:0];
            5'd5:    rdata_s = lc_wide_s[7:0];
            5'd6:    rdata_s = frame_cnt_q;
            default: rdata_s = 8'h00;
        endcase
    end

    // Read data register, updated only on a selected read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            csr_readdata_q <= 8'h00;
        end else if (rd_en_s) begin
            csr_readdata_q <= rdata_s;
        end
    end

    assign csr_readdata = csr_readdata_q;
    assign pix_valid    = pix_valid_q;
    assign pix_data     = pix_data_q;
    assign frame_start  = frame_start_q;
    assign irq          = |(irq_flag_q & irq_en_q);

endmodule

// File: tb/tb_cam_capture_ctrl.sv
module tb_cam_capture_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       chip_select = 1'b0;
    logic [4:0] csr_address = 5'd0;
    logic       csr_read = 1'b0;
    logic [7:0] csr_readdata;
    logic       csr_write = 1'b0;
    logic [7:0] csr_writedata = 8'h00;
    logic       irq;
    logic       cam_vsync = 1'b1;
    logic       cam_href = 1'b0;
    logic       cam_pclk = 1'b0;
    logic [7:0] cam_data = 8'h00;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       fifo_full = 1'b0;
    logic       frame_start;

    cam_capture_ctrl #(.SYNC_STAGES(2), .LINE_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .chip_select(chip_select),
        .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
        .csr_write(csr_write), .csr_writedata(csr_writedata), .irq(irq),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_pclk(cam_pclk),
        .cam_data(cam_data), .pix_valid(pix_valid), .pix_data(pix_data),
        .fifo_full(fifo_full), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state: window rule, FIFO back-pressure map, expectations.
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         m_active = 1'b0;
    int         m_ls = 0;
    int         m_lc = 0;
    bit         exp_ovf = 1'b0;
    bit         ff_map[8][8];
    int         fs_cnt = 0;
    int         exp_frames = 0;

    // Monitor collects every accepted pixel and frame_start pulse.
    always @(negedge clk) begin
        if (pix_valid) got_q.push_back(pix_data);
        if (frame_start) fs_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit in_win(input int ln);
        return (ln >= m_ls) && ((m_lc == 0) || (ln < m_ls + m_lc));
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic csr_wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        chip_select = 1'b1; csr_write = 1'b1; csr_address = a; csr_writedata = d;
        @(negedge clk);
        chip_select = 1'b0; csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [4:0] a, output logic [7:0] d);
        @(negedge clk);
        chip_select = 1'b1; csr_read = 1'b1; csr_address = a;
        @(negedge clk);
        chip_select = 1'b0; csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic clear_ff_map();
        for (int l = 0; l < 8; l++)
            for (int p = 0; p < 8; p++) ff_map[l][p] = 1'b0;
    endtask

    task automatic drive_pixel(input int ln, input int p, input bit rnd);
        logic [7:0] d;
        bit ff;
        d  = rnd ? 8'($urandom) : 8'(ln * 16 + p);
        ff = ff_map[ln][p];
        if (m_active && in_win(ln)) begin
            if (ff) exp_ovf = 1'b1;
            else    exp_q.push_back(d);
        end
        cam_data = d; fifo_full = ff; cam_pclk = 1'b0;
        wait_clk(4);
        cam_pclk = 1'b1;
        wait_clk(4);
        fifo_full = 1'b0;
    endtask

    task automatic drive_line(input int ln, input int npix, input bit rnd);
        cam_href = 1'b1;
        wait_clk(2);
        for (int p = 0; p < npix; p++) drive_pixel(ln, p, rnd);
        cam_pclk = 1'b0;
        wait_clk(4);
        cam_href = 1'b0;
        wait_clk(8);
    endtask

    task automatic vs_lead();
        cam_vsync = 1'b0; wait_clk(8);
        cam_vsync = 1'b1; wait_clk(16);
    endtask

    task automatic frame_body(input int nl, input int np, input bit rnd);
        cam_vsync = 1'b0; wait_clk(8);
        for (int l = 0; l < nl; l++) drive_line(l, np, rnd);
        wait_clk(8);
        cam_vsync = 1'b1; wait_clk(16);
    endtask

    task automatic start_scenario();
        exp_q.delete(); got_q.delete(); exp_ovf = 1'b0; clear_ff_map();
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        reset_n = 1'b0;
        wait_clk(3);
        reset_n = 1'b1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (pix_valid !== 1'b0 || pix_data !== 8'h00 || frame_start !== 1'b0) begin
            failures++; $display("FAIL reset_pix got=%b/%h/%b exp=0/00/0", pix_valid, pix_data, frame_start); end
        checks++; if (csr_readdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", csr_readdata); end
        for (int a = 0; a < 8; a++) begin
            csr_rd(5'(a), rd);
            checks++; if (rd !== 8'h00) begin failures++; $display("FAIL reset_csr%0d got=%h exp=00", a, rd); end
        end
    endtask

    task automatic test_window();
        logic [7:0] rd;
        int fs0;
        start_scenario();
        m_ls = 2; m_lc = 3;
        csr_wr(5'd4, 8'd2); csr_wr(5'd5, 8'd3); csr_wr(5'd2, 8'h01);
        fs0 = fs_cnt;
        m_active = 1'b1;
        csr_wr(5'd0, 8'h01);
        vs_lead();
        frame_body(6, 4, 1'b0);
        m_active = 1'b0;
        exp_frames++;
        checks++; if (got_q.size() !== 12) begin failures++; $display("FAIL win_count got=%0d exp=12", got_q.size()); end
        else begin
            for (int i = 0; i < 12; i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL win_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
            end
            checks++; if (got_q[0] !== 8'h20 || got_q[11] !== 8'h43) begin
                failures++; $display("FAIL win_ends got=%h..%h exp=20..43", got_q[0], got_q[11]); end
        end
        checks++; if (fs_cnt - fs0 !== 1) begin failures++; $display("FAIL win_frame_start got=%0d exp=1", fs_cnt - fs0); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL win_irq got=%b exp=1", irq); end
        csr_rd(5'd6, rd);
        checks++; if (rd !== 8'(exp_frames)) begin failures++; $display("FAIL win_frame_cnt got=%0d exp=%0d", rd, exp_frames); end
        csr_rd(5'd1, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL win_status got=%h exp=00", rd); end
        csr_rd(5'd3, rd);
        checks++; if (rd !== 8'h01) begin failures++; $display("FAIL win_flags got=%h exp=01", rd); end
    endtask

    task automatic test_continuous();
        logic [7:0] rd;
        start_scenario();
        m_ls = 0; m_lc = 0;
        csr_wr(5'd4, 8'd0); csr_wr(5'd5, 8'd0);
        m_active = 1'b1;
        csr_wr(5'd0, 8'h03);
        vs_lead();
        for (int f = 0; f < 3; f++) frame_body(4, 4, 1'b1);
        m_active = 1'b0;
        exp_frames += 3;
        checks++; if (got_q.size() !== 48) begin failures++; $display("FAIL cont_count got=%0d exp=48", got_q.size()); end
        else begin
            for (int i = 0; i < 48; i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL cont_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
            end
        end
        csr_rd(5'd6, rd);
        checks++; if (rd !== 8'(exp_frames)) begin failures++; $display("FAIL cont_frame_cnt got=%0d exp=%0d", rd, exp_frames); end
        csr_rd(5'd1, rd);
        checks++; if (rd !== 8'h0A) begin failures++; $display("FAIL cont_status got=%h exp=0a", rd); end
        csr_wr(5'd3, 8'h01);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL cont_irq_clear got=%b exp=0", irq); end
        csr_wr(5'd0, 8'h04);
        csr_rd(5'd1, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL cont_abort_status got=%h exp=00", rd); end
        csr_rd(5'd0, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL cont_abort_ctrl got=%h exp=00", rd); end
    endtask

    task automatic test_overflow();
        logic [7:0] rd;
        start_scenario();
        csr_wr(5'd3, 8'h03); csr_wr(5'd2, 8'h02);
        ff_map[0][1] = 1'b1; ff_map[2][2] = 1'b1;
        m_active = 1'b1;
        csr_wr(5'd0, 8'h01);
        vs_lead();
        frame_body(4, 4, 1'b1);
        m_active = 1'b0;
        exp_frames++;
        checks++; if (got_q.size() !== 14) begin failures++; $display("FAIL ovf_count got=%0d exp=14", got_q.size()); end
        else begin
            for (int i = 0; i < 14; i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
            end
        end
        csr_rd(5'd3, rd);
        checks++; if (rd !== {6'b000000, exp_ovf, 1'b1}) begin failures++; $display("FAIL ovf_flags got=%h exp=%h", rd, {6'b000000, exp_ovf, 1'b1}); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL ovf_irq got=%b exp=1", irq); end
        clear_ff_map();
    endtask

    task automatic test_abort();
        logic [7:0] rd;
        start_scenario();
        csr_wr(5'd3, 8'h03); csr_wr(5'd2, 8'h03);
        csr_wr(5'd0, 8'h05);
        csr_rd(5'd1, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL abort_wins_arm got=%h exp=00", rd); end
        m_active = 1'b1;
        csr_wr(5'd0, 8'h01);
        vs_lead();
        cam_vsync = 1'b0; wait_clk(8);
        drive_line(0, 4, 1'b1);
        cam_href = 1'b1; wait_clk(2);
        drive_pixel(1, 0, 1'b1);
        drive_pixel(1, 1, 1'b1);
        csr_wr(5'd0, 8'h04);
        m_active = 1'b0;
        csr_rd(5'd1, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL abort_status got=%h exp=00", rd); end
        drive_pixel(1, 2, 1'b1);
        drive_pixel(1, 3, 1'b1);
        cam_pclk = 1'b0; wait_clk(4); cam_href = 1'b0; wait_clk(8);
        drive_line(2, 4, 1'b1);
        cam_vsync = 1'b1; wait_clk(16);
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL abort_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL abort_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
            end
        end
        csr_rd(5'd6, rd);
        checks++; if (rd !== 8'(exp_frames)) begin failures++; $display("FAIL abort_frame_cnt got=%0d exp=%0d", rd, exp_frames); end
        csr_rd(5'd3, rd);
        checks++; if (rd[0] !== 1'b0) begin failures++; $display("FAIL abort_done_flag got=%b exp=0", rd[0]); end
    endtask

    task automatic test_random();
        logic [7:0] rd;
        int nl, np;
        for (int it = 0; it < 4; it++) begin
            start_scenario();
            m_ls = $urandom_range(0, 3); m_lc = $urandom_range(0, 3);
            nl = $urandom_range(3, 6);   np = $urandom_range(2, 5);
            for (int l = 0; l < 8; l++)
                for (int p = 0; p < 8; p++) ff_map[l][p] = ($urandom_range(0, 5) == 0);
            csr_wr(5'd3, 8'h03);
            csr_wr(5'd4, 8'(m_ls)); csr_wr(5'd5, 8'(m_lc));
            m_active = 1'b1;
            csr_wr(5'd0, 8'h01);
            vs_lead();
            frame_body(nl, np, 1'b1);
            m_active = 1'b0;
            exp_frames++;
            checks++; if (got_q.size() !== exp_q.size()) begin
                failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d ls=%0d lc=%0d", it, got_q.size(), exp_q.size(), m_ls, m_lc); end
            else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd%0d_byte%0d got=%h exp=%h", it, i, got_q[i], exp_q[i]); end
                end
            end
            csr_rd(5'd3, rd);
            checks++; if (rd !== {6'b000000, exp_ovf, 1'b1}) begin failures++; $display("FAIL rnd%0d_flags got=%h exp=%h", it, rd, {6'b000000, exp_ovf, 1'b1}); end
            csr_rd(5'd6, rd);
            checks++; if (rd !== 8'(exp_frames)) begin failures++; $display("FAIL rnd%0d_frame_cnt got=%0d exp=%0d", it, rd, exp_frames); end
        end
        clear_ff_map();
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd;
        int fs0;
        start_scenario();
        m_ls = 0; m_lc = 0;
        csr_wr(5'd4, 8'd0); csr_wr(5'd5, 8'd0); csr_wr(5'd2, 8'h03);
        csr_wr(5'd0, 8'h03);
        vs_lead();
        cam_vsync = 1'b0; wait_clk(8);
        drive_line(0, 4, 1'b1);
        reset_n = 1'b0;
        wait_clk(1);
        reset_n = 1'b1;
        exp_frames = 0;
        checks++; if (pix_valid !== 1'b0 || frame_start !== 1'b0 || irq !== 1'b0 || csr_readdata !== 8'h00) begin
            failures++; $display("FAIL rstmid_outputs got=%b/%b/%b/%h exp=0/0/0/00", pix_valid, frame_start, irq, csr_readdata); end
        for (int a = 0; a < 8; a++) begin
            csr_rd(5'(a), rd);
            checks++; if (rd !== 8'h00) begin failures++; $display("FAIL rstmid_csr%0d got=%h exp=00", a, rd); end
        end
        got_q.delete();
        fs0 = fs_cnt;
        drive_line(1, 4, 1'b1);
        cam_vsync = 1'b1; wait_clk(16);
        vs_lead();
        frame_body(4, 4, 1'b1);
        checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL rstmid_no_pix got=%0d exp=0", got_q.size()); end
        checks++; if (fs_cnt !== fs0) begin failures++; $display("FAIL rstmid_no_fs got=%0d exp=%0d", fs_cnt, fs0); end
    endtask

    initial begin
        clear_ff_map();
        wait_clk(2);
        test_reset();
        test_window();
        test_continuous();
        test_overflow();
        test_abort();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
